palette_lut: RTL and testbench

Parametrised, run-time writable colour look-up table for the decoder's overlay/caption path.
- Holds NUM_PAL palettes of 2^IDX_W entries, each COLOR_W bits (three equal channels).
- Selects the active palette and a brightness fade factor atomically at frame start.
- Maps a stream of pixel indices to faded RGB with a transparency flag.
- Sits between the index-decoding stage and the overlay mixer.

---
 rtl/palette_pkg.sv | 28 ++
 rtl/palette_fade.sv | 60 ++++++
 rtl/palette_lut.sv | 115 +++++++++++
 tb/tb_palette_lut.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/palette_pkg.sv
// Shared constants and helpers for the overlay colour look-up table.
package palette_pkg;

  localparam int FADE_W = 8;

  function automatic int ch_w(input int color_w);
    return color_w / 3;
  endfunction

  function automatic int pal_w(input int num_pal);
    return (num_pal > 1) ? $clog2(num_pal) : 1;
  endfunction

  // Reset contents: a full-scale grey ramp across the palette depth.
  function automatic longint unsigned grey_ch(
    input int i,
    input int idx_w,
    input int chw
  );
    longint unsigned top_v;
    longint unsigned den;
    top_v = (64'd1 << chw) - 64'd1;
    den   = (64'd1 << idx_w) - 64'd1;
    if (den == 64'd0) return 64'd0;
    return (longint'(i) * top_v) / den;
  endfunction

endpackage

// File: rtl/palette_fade.sv
// Second pipeline stage: per-channel brightness scaling of a looked-up colour.
module palette_fade
  import palette_pkg::*;
#(
  parameter int CH_W = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  input  logic [3*CH_W-1:0]   i_color,
  input  logic                i_transparent,
  input  logic [FADE_W-1:0]   i_fade,
  output logic                o_valid,
  output logic [3*CH_W-1:0]   o_color,
  output logic                o_transparent
);

  localparam int PW = CH_W + FADE_W + 1;

  logic [FADE_W:0]     scale;
  logic [PW-1:0]       prod;
  logic                valid_d, valid_q;
  logic [3*CH_W-1:0]   color_d, color_q;
  logic                trans_d, trans_q;

  assign scale = {1'b0, i_fade} + (FADE_W+1)'(1);

  // Outputs hold their last value while no pixel is presented.
  always_comb begin
    valid_d = i_valid;
    color_d = color_q;
    trans_d = trans_q;
    prod    = '0;
    if (i_valid) begin
      trans_d = i_transparent;
      for (int c = 0; c < 3; c++) begin
        prod = PW'(i_color[c*CH_W +: CH_W]) * PW'(scale);
        color_d[c*CH_W +: CH_W] =
          i_transparent ? '0 : CH_W'(prod >> FADE_W);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      color_q <= '0;
      trans_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      color_q <= color_d;
      trans_q <= trans_d;
    end
  end

  assign o_valid       = valid_q;
  assign o_color       = color_q;
  assign o_transparent = trans_q;

endmodule

// File: rtl/palette_lut.sv
// Run-time writable multi-palette colour LUT with frame-atomic palette/fade
// selection and a fixed two-cycle lookup pipeline.
module palette_lut
  import palette_pkg::*;
#(
  parameter  int IDX_W           = 4,
  parameter  int COLOR_W         = 24,
  parameter  int NUM_PAL         = 4,
  parameter  int TRANSPARENT_IDX = 0,
  localparam int PAL_W           = pal_w(NUM_PAL)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_wr_en,
  input  logic [PAL_W-1:0]   i_wr_pal,
  input  logic [IDX_W-1:0]   i_wr_idx,
  input  logic [COLOR_W-1:0] i_wr_color,
  input  logic [PAL_W-1:0]   i_pal_sel,
  input  logic [7:0]         i_fade,
  input  logic               i_frame_start,
  input  logic               i_valid,
  input  logic [IDX_W-1:0]   i_idx,
  output logic               o_valid,
  output logic [COLOR_W-1:0] o_color,
  output logic               o_transparent
);

  localparam int CH_W  = ch_w(COLOR_W);
  localparam int DEPTH = 1 << IDX_W;

  logic [COLOR_W-1:0] tbl_d [NUM_PAL][DEPTH];
  logic [COLOR_W-1:0] tbl_q [NUM_PAL][DEPTH];
  logic [PAL_W-1:0]   pal_d, pal_q;
  logic [FADE_W-1:0]  fade_d, fade_q;
  logic               s1_valid_d, s1_valid_q;
  logic [COLOR_W-1:0] s1_color_d, s1_color_q;
  logic               s1_trans_d, s1_trans_q;
  logic [FADE_W-1:0]  s1_fade_d, s1_fade_q;

  // Writes to a palette slot beyond NUM_PAL match no entry.
  always_comb begin
    tbl_d = tbl_q;
    for (int p = 0; p < NUM_PAL; p++) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (i_wr_en && PAL_W'(p) == i_wr_pal &&
            IDX_W'(e) == i_wr_idx) begin
          tbl_d[p][e] = i_wr_color;
        end
      end
    end
  end

  always_comb begin
    pal_d  = pal_q;
    fade_d = fade_q;
    if (i_frame_start) begin
      fade_d = i_fade;
      if ({1'b0, i_pal_sel} < (PAL_W+1)'(NUM_PAL)) begin
        pal_d = i_pal_sel;
      end
    end
  end

  // Fade is captured with the pixel so a commit never splits the pair.
  always_comb begin
    s1_valid_d = i_valid;
    s1_color_d = s1_color_q;
    s1_trans_d = s1_trans_q;
    s1_fade_d  = s1_fade_q;
    if (i_valid) begin
      s1_color_d = tbl_q[pal_q][i_idx];
      s1_trans_d = (i_idx == IDX_W'(TRANSPARENT_IDX));
      s1_fade_d  = fade_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int p = 0; p < NUM_PAL; p++) begin
        for (int e = 0; e < DEPTH; e++) begin
          tbl_q[p][e] <= {3{CH_W'(grey_ch(e, IDX_W, CH_W))}};
        end
      end
      pal_q      <= '0;
      fade_q     <= '1;
      s1_valid_q <= 1'b0;
      s1_color_q <= '0;
      s1_trans_q <= 1'b0;
      s1_fade_q  <= '1;
    end else begin
      tbl_q      <= tbl_d;
      pal_q      <= pal_d;
      fade_q     <= fade_d;
      s1_valid_q <= s1_valid_d;
      s1_color_q <= s1_color_d;
      s1_trans_q <= s1_trans_d;
      s1_fade_q  <= s1_fade_d;
    end
  end

  palette_fade #(
    .CH_W (CH_W)
  ) u_fade (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_valid       (s1_valid_q),
    .i_color       (s1_color_q),
    .i_transparent (s1_trans_q),
    .i_fade        (s1_fade_q),
    .o_valid       (o_valid),
    .o_color       (o_color),
    .o_transparent (o_transparent)
  );

endmodule

// File: tb/tb_palette_lut.sv
// Scoreboard bench for palette_lut: stimulus pushes model predictions,
// a negedge monitor pops and checks them against the DUT output.
module tb_palette_lut;

  localparam int NP = 3;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_wr_en = 1'b0;
  logic [1:0]  i_wr_pal = '0;
  logic [3:0]  i_wr_idx = '0;
  logic [23:0] i_wr_color = '0;
  logic [1:0]  i_pal_sel = '0;
  logic [7:0]  i_fade = 8'd255;
  logic        i_frame_start = 1'b0;
  logic        i_valid = 1'b0;
  logic [3:0]  i_idx = '0;
  logic        o_valid;
  logic [23:0] o_color;
  logic        o_transparent;

  palette_lut #(
    .IDX_W           (4),
    .COLOR_W         (24),
    .NUM_PAL         (NP),
    .TRANSPARENT_IDX (0)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_wr_en       (i_wr_en),
    .i_wr_pal      (i_wr_pal),
    .i_wr_idx      (i_wr_idx),
    .i_wr_color    (i_wr_color),
    .i_pal_sel     (i_pal_sel),
    .i_fade        (i_fade),
    .i_frame_start (i_frame_start),
    .i_valid       (i_valid),
    .i_idx         (i_idx),
    .o_valid       (o_valid),
    .o_color       (o_color),
    .o_transparent (o_transparent)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int          cyc;
    logic [23:0] col;
    logic        tr;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [23:0] mdl [NP][16];
  int          m_pal;
  int          m_fade;

  always @(posedge i_clk) cyc <= cyc + 1;

  function automatic logic [23:0] fade_ref(logic [23:0] c, int f);
    int r;
    r = 0;
    for (int ch = 0; ch < 3; ch++) begin
      r += ((int'(c[ch*8 +: 8]) * (f + 1)) / 256) << (8 * ch);
    end
    return 24'(r);
  endfunction

  task automatic model_reset();
    for (int p = 0; p < NP; p++)
      for (int e = 0; e < 16; e++)
        mdl[p][e] = {3{8'((e * 255) / 15)}};
    m_pal  = 0;
    m_fade = 255;
  endtask

  task automatic step(
    input logic        v,
    input logic [3:0]  idx,
    input logic        we = 1'b0,
    input logic [1:0]  wp = 2'd0,
    input logic [3:0]  wi = 4'd0,
    input logic [23:0] wc = 24'd0,
    input logic        fs = 1'b0,
    input logic [1:0]  ps = 2'd0,
    input logic [7:0]  fd = 8'd255
  );
    exp_t e;
    i_valid       = v;
    i_idx         = idx;
    i_wr_en       = we;
    i_wr_pal      = wp;
    i_wr_idx      = wi;
    i_wr_color    = wc;
    i_frame_start = fs;
    i_pal_sel     = ps;
    i_fade        = fd;
    if (v) begin
      e.cyc = cyc;
      e.tr  = (idx == 4'd0);
      e.col = e.tr ? 24'd0 : fade_ref(mdl[m_pal][idx], m_fade);
      q.push_back(e);
    end
    if (we && int'(wp) < NP) mdl[wp][wi] = wc;
    if (fs) begin
      if (int'(ps) < NP) m_pal = int'(ps);
      m_fade = int'(fd);
    end
    @(posedge i_clk);
    #1;
  endtask

  always @(negedge i_clk) begin
    if (i_rst) begin
      n_cmp++;
      if (o_valid !== 1'b0 || o_color !== 24'd0 ||
          o_transparent !== 1'b0) begin
        n_bad++;
        $display("FAIL reset: got v=%b col=%h tr=%b, want 0/000000/0",
                 o_valid, o_color, o_transparent);
      end
    end else if (o_valid === 1'b1) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL spurious: got col=%h @%0d, want no output",
                 o_color, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (o_color !== e.col || o_transparent !== e.tr ||
            cyc != e.cyc + 2) begin
          n_bad++;
          $display("FAIL lookup: got col=%h tr=%b @%0d, want col=%h tr=%b @%0d",
                   o_color, o_transparent, cyc, e.col, e.tr, e.cyc + 2);
        end
      end
    end else if (q.size() > 0 && cyc >= q[0].cyc + 2) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missing: got o_valid=%b @%0d, want col=%h",
               o_valid, cyc, e.col);
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;

    step(1, 4'd0);
    step(1, 4'd1);
    step(1, 4'd15);

    step(1, 4'd3, 1, 2'd0, 4'd3, 24'hff8040);
    step(1, 4'd3);

    step(0, 4'd0, 1, 2'd2, 4'd5, 24'h00ff00);
    step(1, 4'd5, 0, 2'd0, 4'd0, 24'd0, 0, 2'd2, 8'd255);
    step(1, 4'd5, 0, 2'd0, 4'd0, 24'd0, 1, 2'd2, 8'd255);
    step(1, 4'd5);

    step(0, 4'd0, 0, 2'd0, 4'd0, 24'd0, 1, 2'd0, 8'd127);
    step(1, 4'd3);
    step(0, 4'd0, 0, 2'd0, 4'd0, 24'd0, 1, 2'd0, 8'd0);
    step(1, 4'd3);
    step(0, 4'd0, 0, 2'd0, 4'd0, 24'd0, 1, 2'd0, 8'd255);
    step(1, 4'd3);

    for (int i = 0; i < 20; i++) begin
      step(1, 4'($urandom_range(0, 15)), 0, 2'd0, 4'd0, 24'd0,
           (i == 10), 2'(m_pal), 8'd127);
    end

    step(0, 4'd0, 1, 2'd3, 4'd7, 24'h123456);
    step(0, 4'd0, 0, 2'd0, 4'd0, 24'd0, 1, 2'd3, 8'd200);
    step(1, 4'd7);
    step(0, 4'd0, 0, 2'd0, 4'd0, 24'd0, 1, 2'd1, 8'd255);
    step(1, 4'd7);
    step(0, 4'd0, 0, 2'd0, 4'd0, 24'd0, 1, 2'd2, 8'd255);
    step(1, 4'd7);

    step(1, 4'd3);
    step(1, 4'd4);
    i_valid = 1'b0;
    i_frame_start = 1'b0;
    i_wr_en = 1'b0;
    i_rst = 1'b1;
    q.delete();
    model_reset();
    @(negedge i_clk);
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    step(1, 4'd3);
    step(1, 4'd5);

    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) != 0),
           4'($urandom_range(0, 15)),
           1'($urandom_range(0, 3) == 0),
           2'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)),
           24'($urandom),
           1'($urandom_range(0, 15) == 0),
           2'($urandom_range(0, 3)),
           8'($urandom_range(0, 255)));
    end

    repeat (6) step(0, 4'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
